// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and types for the scoreboarded register file.
//               DEFAULT_XLEN / DEFAULT_NREGS give the standard configuration;
//               reg_addr_t and xlen_t are sized for that configuration.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_NREGS);

    typedef logic [DEFAULT_AW-1:0]   reg_addr_t;
    typedef logic [DEFAULT_XLEN-1:0] xlen_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard_if
// Description : Bus bundle between the register file and its clients.
//               master : decode / writeback / multi-cycle units (drive
//                        addresses, writes, reserve and late writeback)
//               slave  : the register file itself
// Ports       : rd_addr/rd_data/rd_busy  - NRD packed read ports
//               wr_en/wr_addr/wr_data    - primary writeback
//               rsv_valid/rsv_addr/rsv_ready - reserve handshake
//               lwb_valid/lwb_addr/lwb_data/lwb_ready - late writeback
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int NREGS = DEFAULT_NREGS,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;

    logic                rsv_valid;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ready;

    logic                lwb_valid;
    logic [AW-1:0]       lwb_addr;
    logic [XLEN-1:0]     lwb_data;
    logic                lwb_ready;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
               rsv_valid, rsv_addr, lwb_valid, lwb_addr, lwb_data,
        input  rd_data, rd_busy, rsv_ready, lwb_ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
               rsv_valid, rsv_addr, lwb_valid, lwb_addr, lwb_data,
        output rd_data, rd_busy, rsv_ready, lwb_ready
    );

endinterface
`default_nettype wire

// File: rtl/regfile_rdport.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rdport
// Description : One combinational read port: zero-register override plus
//               same-cycle forwarding from the late writeback and primary
//               write buses.
// Ports       : i_rd_addr   - address being read
//               i_row_data  - storage row already selected by i_rd_addr
//               i_row_busy  - registered busy bit of that row
//               i_wr_*      - primary write bus
//               i_lwb_fire  - late writeback accepted this cycle
//               i_lwb_*     - late writeback bus
//               o_rd_data   - read data
//               o_rd_busy   - pending reservation flag
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rdport #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  wire logic [AW-1:0]   i_rd_addr,
    input  wire logic [XLEN-1:0] i_row_data,
    input  wire logic            i_row_busy,
    input  wire logic            i_wr_en,
    input  wire logic [AW-1:0]   i_wr_addr,
    input  wire logic [XLEN-1:0] i_wr_data,
    input  wire logic            i_lwb_fire,
    input  wire logic [AW-1:0]   i_lwb_addr,
    input  wire logic [XLEN-1:0] i_lwb_data,
    output logic      [XLEN-1:0] o_rd_data,
    output logic                 o_rd_busy
);

    logic w_is_zero;
    logic w_hit_lwb;
    logic w_hit_wr;

    always_comb begin
        w_is_zero = ZERO_REG && (i_rd_addr == '0);
        w_hit_lwb = BYPASS && i_lwb_fire && (i_lwb_addr == i_rd_addr);
        w_hit_wr  = BYPASS && i_wr_en && (i_wr_addr == i_rd_addr);

        o_rd_data = i_row_data;
        o_rd_busy = i_row_busy;
        if (w_is_zero) begin
            o_rd_data = '0;
            o_rd_busy = 1'b0;
        end else if (w_hit_lwb) begin
            // The late writeback is the release of this reservation.
            o_rd_data = i_lwb_data;
            o_rd_busy = 1'b0;
        end else if (w_hit_wr) begin
            // Primary writes never touch busy, so keep the stored flag.
            o_rd_data = i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Parametrised register file with NRD combinational read
//               ports, optional hardwired zero register, write-to-read
//               bypass, a late writeback port and a per-register busy
//               scoreboard driven by a reserve/release handshake.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - regfile_scoreboard_if slave modport (reads, primary
//                       write, reserve, late writeback)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input wire logic         clk,
    input wire logic         rst_n,
    regfile_scoreboard_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     r_regs [NREGS];
    logic [NREGS-1:0]    r_busy;

    logic                w_lwb_ready;
    logic                w_lwb_fire;
    logic                w_lwb_commit;
    logic                w_wr_commit;
    logic                w_rsv_is_zero;
    logic                w_rsv_ready;
    logic                w_rsv_fire;

    logic [XLEN-1:0]     w_rd_data   [NRD];
    logic                w_rd_busy   [NRD];
    logic [NRD*XLEN-1:0] w_rd_data_p;
    logic [NRD-1:0]      w_rd_busy_p;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        // Primary port wins an address collision; lwb must hold and retry.
        w_lwb_ready   = !(bus.wr_en && (bus.wr_addr == bus.lwb_addr));
        w_lwb_fire    = bus.lwb_valid && w_lwb_ready;
        w_lwb_commit  = w_lwb_fire && !(ZERO_REG && (bus.lwb_addr == '0));
        w_wr_commit   = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));

        // Only the registered busy vector is consulted, so a release in the
        // same cycle does not make the register reservable until next cycle.
        w_rsv_is_zero = ZERO_REG && (bus.rsv_addr == '0);
        w_rsv_ready   = w_rsv_is_zero || !r_busy[bus.rsv_addr];
        w_rsv_fire    = bus.rsv_valid && w_rsv_ready && !w_rsv_is_zero;
    end

    assign bus.lwb_ready = w_lwb_ready;
    assign bus.rsv_ready = w_rsv_ready;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            // The two commits never target the same row: a collision
            // blocks the late writeback.
            if (w_wr_commit) begin
                r_regs[bus.wr_addr] <= bus.wr_data;
            end
            if (w_lwb_commit) begin
                r_regs[bus.lwb_addr] <= bus.lwb_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (w_rsv_fire) begin
                r_busy[bus.rsv_addr] <= 1'b1;
            end
            // Release is written last so it dominates a same-row reserve.
            if (w_lwb_fire) begin
                r_busy[bus.lwb_addr] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NRD; g++) begin : g_rdport
        logic [AW-1:0] w_addr;
        assign w_addr = bus.rd_addr[g*AW +: AW];

        regfile_rdport #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .i_rd_addr  (w_addr),
            .i_row_data (r_regs[w_addr]),
            .i_row_busy (r_busy[w_addr]),
            .i_wr_en    (bus.wr_en),
            .i_wr_addr  (bus.wr_addr),
            .i_wr_data  (bus.wr_data),
            .i_lwb_fire (w_lwb_fire),
            .i_lwb_addr (bus.lwb_addr),
            .i_lwb_data (bus.lwb_data),
            .o_rd_data  (w_rd_data[g]),
            .o_rd_busy  (w_rd_busy[g])
        );
    end

    always_comb begin
        w_rd_data_p = '0;
        w_rd_busy_p = '0;
        for (int i = 0; i < NRD; i++) begin
            w_rd_data_p[i*XLEN +: XLEN] = w_rd_data[i];
            w_rd_busy_p[i]              = w_rd_busy[i];
        end
    end

    assign bus.rd_data = w_rd_data_p;
    assign bus.rd_busy = w_rd_busy_p;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed self-checking bench for regfile_scoreboard in its
//               default configuration (32x32, two read ports, zero register
//               and bypass enabled).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) rf_if ();

    regfile_scoreboard #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (1'b1),
        .BYPASS   (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic xlen_t rd0();
        return rf_if.rd_data[XLEN-1:0];
    endfunction

    function automatic xlen_t rd1();
        return rf_if.rd_data[2*XLEN-1:XLEN];
    endfunction

    task automatic set_idle();
        rf_if.wr_en     = 1'b0;
        rf_if.wr_addr   = '0;
        rf_if.wr_data   = '0;
        rf_if.rsv_valid = 1'b0;
        rf_if.rsv_addr  = '0;
        rf_if.lwb_valid = 1'b0;
        rf_if.lwb_addr  = '0;
        rf_if.lwb_data  = '0;
    endtask

    task automatic set_rd(input int port, input reg_addr_t addr);
        rf_if.rd_addr[port*AW +: AW] = addr;
    endtask

    // Reset asserted between clock edges must clear everything immediately.
    task automatic test_reset();
        set_idle();
        set_rd(0, 5'd5);
        set_rd(1, 5'd31);
        rf_if.rsv_addr = 5'd5;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rd0() !== 32'h0) begin errors++; $display("FAIL reset_rd0: got %h exp %h", rd0(), 32'h0); end
        checks++; if (rd1() !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h exp %h", rd1(), 32'h0); end
        checks++; if (rf_if.rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b exp %b", rf_if.rd_busy, 2'b00); end
        checks++; if (rf_if.rsv_ready !== 1'b1) begin errors++; $display("FAIL reset_rsv_ready: got %b exp 1", rf_if.rsv_ready); end
        checks++; if (rf_if.lwb_ready !== 1'b1) begin errors++; $display("FAIL reset_lwb_ready: got %b exp 1", rf_if.lwb_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_bypass();
        @(negedge clk);
        rf_if.wr_en   = 1'b1;
        rf_if.wr_addr = 5'd7;
        rf_if.wr_data = 32'hDEADBEEF;
        set_rd(0, 5'd7);
        set_rd(1, 5'd8);
        #1;
        checks++; if (rd0() !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bypass: got %h exp %h", rd0(), 32'hDEADBEEF); end
        checks++; if (rd1() !== 32'h0) begin errors++; $display("FAIL wr_other_port: got %h exp %h", rd1(), 32'h0); end
        @(posedge clk); #1;
        rf_if.wr_en = 1'b0;
        #1;
        checks++; if (rd0() !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_array: got %h exp %h", rd0(), 32'hDEADBEEF); end
        @(negedge clk);
        rf_if.wr_en   = 1'b1;
        rf_if.wr_addr = 5'd0;
        rf_if.wr_data = 32'h1234;
        set_rd(0, 5'd0);
        #1;
        checks++; if (rd0() !== 32'h0) begin errors++; $display("FAIL zero_bypass: got %h exp %h", rd0(), 32'h0); end
        @(posedge clk); #1;
        rf_if.wr_en = 1'b0;
        #1;
        checks++; if (rd0() !== 32'h0) begin errors++; $display("FAIL zero_array: got %h exp %h", rd0(), 32'h0); end
    endtask

    task automatic test_reserve_release();
        @(negedge clk);
        rf_if.rsv_valid = 1'b1;
        rf_if.rsv_addr  = 5'd9;
        set_rd(0, 5'd9);
        #1;
        checks++; if (rf_if.rsv_ready !== 1'b1) begin errors++; $display("FAIL rsv9_ready: got %b exp 1", rf_if.rsv_ready); end
        checks++; if (rf_if.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL rsv9_busy_pre: got %b exp 0", rf_if.rd_busy[0]); end
        @(posedge clk); #1;
        checks++; if (rf_if.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL rsv9_busy: got %b exp 1", rf_if.rd_busy[0]); end
        checks++; if (rf_if.rsv_ready !== 1'b0) begin errors++; $display("FAIL rsv9_again_ready: got %b exp 0", rf_if.rsv_ready); end
        @(negedge clk);
        rf_if.rsv_valid = 1'b0;
        rf_if.lwb_valid = 1'b1;
        rf_if.lwb_addr  = 5'd9;
        rf_if.lwb_data  = 32'hA5A5A5A5;
        #1;
        checks++; if (rf_if.lwb_ready !== 1'b1) begin errors++; $display("FAIL lwb9_ready: got %b exp 1", rf_if.lwb_ready); end
        checks++; if (rd0() !== 32'hA5A5A5A5) begin errors++; $display("FAIL lwb9_bypass: got %h exp %h", rd0(), 32'hA5A5A5A5); end
        checks++; if (rf_if.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL lwb9_bypass_busy: got %b exp 0", rf_if.rd_busy[0]); end
        @(posedge clk); #1;
        rf_if.lwb_valid = 1'b0;
        #1;
        checks++; if (rf_if.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL lwb9_busy_after: got %b exp 0", rf_if.rd_busy[0]); end
        checks++; if (rd0() !== 32'hA5A5A5A5) begin errors++; $display("FAIL lwb9_array: got %h exp %h", rd0(), 32'hA5A5A5A5); end
    endtask

    task automatic test_port_conflict();
        @(negedge clk);
        rf_if.wr_en     = 1'b1;
        rf_if.wr_addr   = 5'd4;
        rf_if.wr_data   = 32'h11;
        rf_if.lwb_valid = 1'b1;
        rf_if.lwb_addr  = 5'd4;
        rf_if.lwb_data  = 32'h22;
        set_rd(0, 5'd4);
        #1;
        checks++; if (rf_if.lwb_ready !== 1'b0) begin errors++; $display("FAIL conflict_lwb_ready: got %b exp 0", rf_if.lwb_ready); end
        checks++; if (rd0() !== 32'h11) begin errors++; $display("FAIL conflict_bypass: got %h exp %h", rd0(), 32'h11); end
        @(posedge clk); #1;
        rf_if.wr_en = 1'b0;
        #1;
        checks++; if (rf_if.lwb_ready !== 1'b1) begin errors++; $display("FAIL retry_lwb_ready: got %b exp 1", rf_if.lwb_ready); end
        @(posedge clk); #1;
        rf_if.lwb_valid = 1'b0;
        #1;
        checks++; if (rd0() !== 32'h22) begin errors++; $display("FAIL retry_array: got %h exp %h", rd0(), 32'h22); end
    endtask

    task automatic test_simultaneous();
        // Make reg 6 busy first.
        @(negedge clk);
        rf_if.rsv_valid = 1'b1;
        rf_if.rsv_addr  = 5'd6;
        @(negedge clk);
        rf_if.rsv_addr  = 5'd3;
        rf_if.lwb_valid = 1'b1;
        rf_if.lwb_addr  = 5'd6;
        rf_if.lwb_data  = 32'h66;
        #1;
        checks++; if (rf_if.rsv_ready !== 1'b1) begin errors++; $display("FAIL simul_rsv3_ready: got %b exp 1", rf_if.rsv_ready); end
        @(posedge clk); #1;
        set_idle();
        set_rd(0, 5'd3);
        set_rd(1, 5'd6);
        #1;
        checks++; if (rf_if.rd_busy !== 2'b01) begin errors++; $display("FAIL simul_busy: got %b exp %b", rf_if.rd_busy, 2'b01); end
        checks++; if (rd1() !== 32'h66) begin errors++; $display("FAIL simul_rel6_data: got %h exp %h", rd1(), 32'h66); end
        @(negedge clk);
        rf_if.rsv_valid = 1'b1;
        rf_if.rsv_addr  = 5'd3;
        rf_if.lwb_valid = 1'b1;
        rf_if.lwb_addr  = 5'd3;
        rf_if.lwb_data  = 32'h33;
        #1;
        checks++; if (rf_if.rsv_ready !== 1'b0) begin errors++; $display("FAIL same_reg_rsv_ready: got %b exp 0", rf_if.rsv_ready); end
        @(posedge clk); #1;
        rf_if.lwb_valid = 1'b0;
        #1;
        checks++; if (rf_if.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL same_reg_busy: got %b exp 0", rf_if.rd_busy[0]); end
        checks++; if (rf_if.rsv_ready !== 1'b1) begin errors++; $display("FAIL same_reg_rsv_retry: got %b exp 1", rf_if.rsv_ready); end
        @(posedge clk); #1;
        rf_if.rsv_valid = 1'b0;
        #1;
        checks++; if (rf_if.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL same_reg_rsv_done: got %b exp 1", rf_if.rd_busy[0]); end
        checks++; if (rd0() !== 32'h33) begin errors++; $display("FAIL same_reg_data: got %h exp %h", rd0(), 32'h33); end
    endtask

    task automatic test_reset_midop();
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            rf_if.rsv_valid = 1'b1;
            rf_if.rsv_addr  = reg_addr_t'(r);
        end
        @(negedge clk);
        set_idle();
        rf_if.wr_en   = 1'b1;
        rf_if.wr_addr = 5'd2;
        rf_if.wr_data = 32'hFF;
        set_rd(0, 5'd2);
        set_rd(1, 5'd4);
        @(posedge clk); #1;
        rf_if.wr_en = 1'b0;
        #1;
        checks++; if (rd0() !== 32'hFF) begin errors++; $display("FAIL busy_write_data: got %h exp %h", rd0(), 32'hFF); end
        checks++; if (rf_if.rd_busy !== 2'b11) begin errors++; $display("FAIL pre_reset_busy: got %b exp %b", rf_if.rd_busy, 2'b11); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rd0() !== 32'h0) begin errors++; $display("FAIL midop_reset_data: got %h exp %h", rd0(), 32'h0); end
        checks++; if (rf_if.rd_busy !== 2'b00) begin errors++; $display("FAIL midop_reset_busy: got %b exp %b", rf_if.rd_busy, 2'b00); end
        rst_n = 1'b1;
        @(negedge clk);
        rf_if.rsv_valid = 1'b1;
        rf_if.rsv_addr  = 5'd2;
        #1;
        checks++; if (rf_if.rsv_ready !== 1'b1) begin errors++; $display("FAIL post_reset_rsv_ready: got %b exp 1", rf_if.rsv_ready); end
        @(posedge clk); #1;
        rf_if.rsv_valid = 1'b0;
        #1;
        checks++; if (rf_if.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL post_reset_rsv_busy: got %b exp 1", rf_if.rd_busy[0]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rf_if.rd_addr = '0;
        test_reset();
        test_write_bypass();
        test_reserve_release();
        test_port_conflict();
        test_simultaneous();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
